// File: rtl/branch_resolve_queue_pkg.sv
// branch_resolve_queue_pkg
// Shared types and helpers for the multi-issue branch resolution queue.
//   - fu_op / cf_t                 : operation and control-flow encodings
//   - branchpredict_sbe_t          : frontend prediction carried with each branch
//   - bp_resolve_t / exception_t   : resolution record and exception record
//   - brq_entry_t                  : one queue slot (resolution + exception)
//   - calc_next_pc / calc_target   : next-PC and jump-target arithmetic
package branch_resolve_queue_pkg;

    localparam int unsigned BRQ_VLEN = 32;
    localparam int unsigned BRQ_XLEN = 64;

    localparam logic [BRQ_XLEN-1:0] INSTR_ADDR_MISALIGNED = '0;

    typedef enum logic [3:0] {
        ADD,    // JAL travels through the branch unit as an add
        EQ,
        NE,
        LTS,
        GES,
        LTU,
        GEU,
        JALR
    } fu_op;

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        cf_t                 cf;
        logic [BRQ_VLEN-1:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic                valid;
        logic [BRQ_VLEN-1:0] pc;
        logic [BRQ_VLEN-1:0] target_address;
        logic                is_mispredict;
        logic                is_taken;
        cf_t                 cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic [BRQ_XLEN-1:0] cause;
        logic [BRQ_XLEN-1:0] tval;
        logic                valid;
    } exception_t;

    typedef struct packed {
        bp_resolve_t res;
        exception_t  ex;
    } brq_entry_t;

    function automatic logic op_is_branch(input fu_op op);
        return (op == EQ) || (op == NE) || (op == LTS) ||
               (op == GES) || (op == LTU) || (op == GEU);
    endfunction

    function automatic logic [BRQ_VLEN-1:0] calc_next_pc(
        input logic [BRQ_VLEN-1:0] pc,
        input logic                is_compressed
    );
        return pc + (is_compressed ? BRQ_VLEN'(2) : BRQ_VLEN'(4));
    endfunction

    // JALR jumps relative to rs1 and drops bit 0; everything else is PC-relative.
    function automatic logic [BRQ_VLEN-1:0] calc_target(
        input fu_op                op,
        input logic [BRQ_VLEN-1:0] pc,
        input logic [BRQ_VLEN-1:0] operand_a,
        input logic [BRQ_VLEN-1:0] imm
    );
        logic [BRQ_VLEN-1:0] sum;
        if (op == JALR) begin
            sum = operand_a + imm;
            sum[0] = 1'b0;
        end else begin
            sum = pc + imm;
        end
        return sum;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_eval.sv
// branch_eval
// Purely combinational resolution of one issued branch/jump.
// Ports:
//   valid_i          branch valid on this port
//   operator_i       operation (branch compare, JAL as ADD, JALR)
//   operand_a_i      JALR base register
//   imm_i            sign-extended offset
//   pc_i             instruction PC
//   is_compressed_i  16-bit instruction flag
//   comp_res_i       ALU compare result, 1 = taken
//   predict_i        frontend prediction
//   result_o         link value (next PC)
//   entry_o          resolution + exception record for the queue
module branch_eval
    import branch_resolve_queue_pkg::*;
(
    input  logic                valid_i,
    input  fu_op                operator_i,
    input  logic [BRQ_VLEN-1:0] operand_a_i,
    input  logic [BRQ_VLEN-1:0] imm_i,
    input  logic [BRQ_VLEN-1:0] pc_i,
    input  logic                is_compressed_i,
    input  logic                comp_res_i,
    input  branchpredict_sbe_t  predict_i,
    output logic [BRQ_VLEN-1:0] result_o,
    output brq_entry_t          entry_o
);

    logic [BRQ_VLEN-1:0] next_pc;
    logic [BRQ_VLEN-1:0] target;

    always_comb begin
        next_pc = calc_next_pc(pc_i, is_compressed_i);
        target  = calc_target(operator_i, pc_i, operand_a_i, imm_i);

        entry_o = '0;
        entry_o.res.valid          = valid_i;
        entry_o.res.pc             = pc_i;
        entry_o.res.target_address = comp_res_i ? target : next_pc;
        entry_o.res.is_taken       = comp_res_i;
        entry_o.res.cf_type        = predict_i.cf;

        if (op_is_branch(operator_i)) begin
            entry_o.res.cf_type       = Branch;
            entry_o.res.is_mispredict = comp_res_i != (predict_i.cf == Branch);
        end

        // A mispredicted return keeps its Return type so the RAS stays consistent.
        if (operator_i == JALR &&
            (predict_i.cf == NoCF || target != predict_i.predict_address)) begin
            entry_o.res.is_mispredict = 1'b1;
            if (predict_i.cf != Return) begin
                entry_o.res.cf_type = JumpR;
            end
        end

        if (comp_res_i && target[0]) begin
            entry_o.ex.valid = 1'b1;
            entry_o.ex.cause = INSTR_ADDR_MISALIGNED;
            entry_o.ex.tval  = {{(BRQ_XLEN-BRQ_VLEN){pc_i[BRQ_VLEN-1]}}, pc_i};
        end
    end

    assign result_o = next_pc;

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// Multi-issue branch resolution with an in-order queue draining one entry
// per cycle to the frontend. A head that mispredicts or faults squashes all
// younger entries when it retires; flush_i empties everything.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               discard all queued and same-cycle entries
//   valid_i .. predict_i  per-port issue inputs (port 0 oldest)
//   ready_o               room for NR_PORTS entries this cycle
//   result_o              per-port link value, combinational
//   res_valid_o/res_ready_i  head handshake
//   resolved_branch_o     head resolution (zero when empty)
//   res_exception_o       head exception (zero when empty)
//   occupancy_o           valid entries
// Optional (macro BRQ_PERF_CNT_EN):
//   br_cnt_o              retired resolutions
//   mispredict_cnt_o      retired resolutions flagged mispredict
// VLEN must equal branch_resolve_queue_pkg::BRQ_VLEN; DEPTH must be a power
// of two and at least NR_PORTS.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned VLEN     = BRQ_VLEN
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [NR_PORTS-1:0]        valid_i,
    output logic                       ready_o,
    input  fu_op                       operator_i      [NR_PORTS],
    input  logic [VLEN-1:0]            operand_a_i     [NR_PORTS],
    input  logic [VLEN-1:0]            imm_i           [NR_PORTS],
    input  logic [VLEN-1:0]            pc_i            [NR_PORTS],
    input  logic [NR_PORTS-1:0]        is_compressed_i,
    input  logic [NR_PORTS-1:0]        comp_res_i,
    input  branchpredict_sbe_t         predict_i       [NR_PORTS],
    output logic [VLEN-1:0]            result_o        [NR_PORTS],
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output bp_resolve_t                resolved_branch_o,
    output exception_t                 res_exception_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
`ifdef BRQ_PERF_CNT_EN
    ,
    output logic [31:0]                br_cnt_o,
    output logic [31:0]                mispredict_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    brq_entry_t       queue_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    brq_entry_t       eval_entry [NR_PORTS];
    logic [PTR_W-1:0] wr_idx     [NR_PORTS];
    logic [CNT_W-1:0] push_cnt;
    brq_entry_t       head_entry;
    logic             push_en;
    logic             pop;
    logic             squash;

    for (genvar g = 0; g < NR_PORTS; g++) begin : g_eval
        branch_eval u_eval (
            .valid_i         (valid_i[g]),
            .operator_i      (operator_i[g]),
            .operand_a_i     (operand_a_i[g]),
            .imm_i           (imm_i[g]),
            .pc_i            (pc_i[g]),
            .is_compressed_i (is_compressed_i[g]),
            .comp_res_i      (comp_res_i[g]),
            .predict_i       (predict_i[g]),
            .result_o        (result_o[g]),
            .entry_o         (eval_entry[g])
        );
    end

    // Compaction: each valid port lands at tail + (number of older valid ports).
    always_comb begin
        push_cnt = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            wr_idx[p] = tail_q + push_cnt[PTR_W-1:0];
            if (valid_i[p]) begin
                push_cnt = push_cnt + 1'b1;
            end
        end
    end

    assign ready_o     = (32'(DEPTH) - 32'(count_q)) >= 32'(NR_PORTS);
    assign push_en     = ready_o;
    assign res_valid_o = (count_q != '0);
    assign head_entry  = queue_q[head_q];
    assign pop         = res_valid_o && res_ready_i;
    assign squash      = pop && (head_entry.res.is_mispredict || head_entry.ex.valid);

    // Empty-queue outputs read as zero so stale slots never leak out.
    assign resolved_branch_o = res_valid_o ? head_entry.res : '0;
    assign res_exception_o   = res_valid_o ? head_entry.ex  : '0;
    assign occupancy_o       = count_q;

    // Control state: flush outranks squash, squash drops same-cycle pushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i || squash) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop);
            if (push_en) begin
                tail_q <= tail_q + push_cnt[PTR_W-1:0];
            end
            count_q <= count_q + (push_en ? push_cnt : '0) - CNT_W'(pop);
        end
    end

    // Payload storage carries no reset; slots are only observed through count_q.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            for (int p = 0; p < NR_PORTS; p++) begin
                if (valid_i[p]) begin
                    queue_q[wr_idx[p]] <= eval_entry[p];
                end
            end
        end
    end

`ifdef BRQ_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q         <= '0;
            mispredict_cnt_q <= '0;
        end else if (pop && !flush_i) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (head_entry.res.is_mispredict) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign br_cnt_o         = br_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
`timescale 1ns/1ps
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    localparam int NR_PORTS = 2;
    localparam int DEPTH    = 4;
    localparam int VL       = BRQ_VLEN;
    localparam int CW       = $clog2(DEPTH+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                flush;
    logic [NR_PORTS-1:0] valid;
    logic                ready;
    fu_op                op    [NR_PORTS];
    logic [VL-1:0]       opa   [NR_PORTS];
    logic [VL-1:0]       imm   [NR_PORTS];
    logic [VL-1:0]       pc    [NR_PORTS];
    logic [NR_PORTS-1:0] compr;
    logic [NR_PORTS-1:0] comp;
    branchpredict_sbe_t  pred  [NR_PORTS];
    logic [VL-1:0]       result[NR_PORTS];
    logic                res_valid;
    logic                res_ready;
    bp_resolve_t         rb;
    exception_t          rex;
    logic [CW-1:0]       occ;
`ifdef BRQ_PERF_CNT_EN
    logic [31:0]         br_cnt;
    logic [31:0]         mis_cnt;
`endif

    branch_resolve_queue #(.NR_PORTS(NR_PORTS), .DEPTH(DEPTH), .VLEN(VL)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .valid_i           (valid),
        .ready_o           (ready),
        .operator_i        (op),
        .operand_a_i       (opa),
        .imm_i             (imm),
        .pc_i              (pc),
        .is_compressed_i   (compr),
        .comp_res_i        (comp),
        .predict_i         (pred),
        .result_o          (result),
        .res_valid_o       (res_valid),
        .res_ready_i       (res_ready),
        .resolved_branch_o (rb),
        .res_exception_o   (rex),
        .occupancy_o       (occ)
`ifdef BRQ_PERF_CNT_EN
        ,
        .br_cnt_o          (br_cnt),
        .mispredict_cnt_o  (mis_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    brq_entry_t exp_q[$];
    brq_entry_t stage_q[$];
    logic [31:0] model_br  = '0;
    logic [31:0] model_mis = '0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference behaviour of one issued port, straight from the resolution rules.
    function automatic brq_entry_t model_entry(int p);
        brq_entry_t e;
        logic [VL-1:0] npc;
        logic [VL-1:0] tgt;
        logic          is_br;
        e   = '0;
        npc = pc[p] + (compr[p] ? 32'd2 : 32'd4);
        if (op[p] == JALR) tgt = (opa[p] + imm[p]) & ~32'd1;
        else               tgt = pc[p] + imm[p];
        is_br = op[p] inside {EQ, NE, LTS, GES, LTU, GEU};
        e.res.valid          = 1'b1;
        e.res.pc             = pc[p];
        e.res.target_address = comp[p] ? tgt : npc;
        e.res.is_taken       = comp[p];
        e.res.cf_type        = pred[p].cf;
        e.res.is_mispredict  = 1'b0;
        if (is_br) begin
            e.res.cf_type       = Branch;
            e.res.is_mispredict = (comp[p] != (pred[p].cf == Branch));
        end
        if (op[p] == JALR && (pred[p].cf == NoCF || tgt != pred[p].predict_address)) begin
            e.res.is_mispredict = 1'b1;
            if (pred[p].cf != Return) e.res.cf_type = JumpR;
        end
        if (comp[p] && tgt[0]) begin
            e.ex.valid = 1'b1;
            e.ex.cause = 64'd0;
            e.ex.tval  = 64'($signed(pc[p]));
        end
        return e;
    endfunction

    // Stimulus side: check link values and record expected accepted pushes.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            for (int p = 0; p < NR_PORTS; p++) begin
                if (valid[p]) begin
                    chk("result_o", 160'(result[p]), 160'(pc[p] + (compr[p] ? 32'd2 : 32'd4)));
                end
            end
            if (!flush && (DEPTH - exp_q.size()) >= NR_PORTS) begin
                for (int p = 0; p < NR_PORTS; p++) begin
                    if (valid[p]) stage_q.push_back(model_entry(p));
                end
            end
        end
    end

    // Monitor: compare the presented head against the scoreboard, then retire.
    always @(negedge clk) begin
        brq_entry_t h;
        #2;
        if (rst) begin
            exp_q.delete();
            stage_q.delete();
            model_br  = '0;
            model_mis = '0;
        end else begin
            chk("occupancy", 160'(occ), 160'(exp_q.size()));
            chk("ready_o", 160'(ready), 160'((DEPTH - exp_q.size()) >= NR_PORTS));
            chk("res_valid", 160'(res_valid), 160'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                chk("head_res", 160'(rb), 160'(h.res));
                chk("head_exc_valid", 160'(rex.valid), 160'(h.ex.valid));
                if (h.ex.valid) chk("head_exc", 160'({rex.cause, rex.tval}), 160'({h.ex.cause, h.ex.tval}));
            end else begin
                chk("idle_res", 160'(rb), 160'(0));
                chk("idle_exc_valid", 160'(rex.valid), 160'(0));
            end
`ifdef BRQ_PERF_CNT_EN
            chk("br_cnt", 160'(br_cnt), 160'(model_br));
            chk("mispredict_cnt", 160'(mis_cnt), 160'(model_mis));
`endif
            if (flush) begin
                exp_q.delete();
                stage_q.delete();
            end else begin
                if (exp_q.size() != 0 && res_ready) begin
                    h = exp_q.pop_front();
                    model_br = model_br + 32'd1;
                    if (h.res.is_mispredict) model_mis = model_mis + 32'd1;
                    if (h.res.is_mispredict || h.ex.valid) begin
                        exp_q.delete();
                        stage_q.delete();
                    end
                end
                while (stage_q.size() != 0) exp_q.push_back(stage_q.pop_front());
            end
        end
    end

    task automatic clear_ports();
        valid = '0;
        compr = '0;
        comp  = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            op[p]   = ADD;
            opa[p]  = '0;
            imm[p]  = '0;
            pc[p]   = '0;
            pred[p] = '0;
        end
    endtask

    task automatic set_port(input int p, input fu_op o, input logic [31:0] pcv,
                            input logic [31:0] opv, input logic [31:0] imv,
                            input logic c, input logic cr, input cf_t cf,
                            input logic [31:0] pa);
        valid[p] = 1'b1;
        op[p]    = o;
        pc[p]    = pcv;
        opa[p]   = opv;
        imm[p]   = imv;
        compr[p] = c;
        comp[p]  = cr;
        pred[p].cf              = cf;
        pred[p].predict_address = pa;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rand_ports();
        int          k;
        int          r;
        logic [31:0] pcv;
        logic [31:0] imv;
        logic [31:0] opv;
        logic [31:0] t;
        logic        cr;
        clear_ports();
        for (int p = 0; p < NR_PORTS; p++) begin
            if ($urandom_range(0, 2) != 0) begin
                k   = $urandom_range(0, 7);
                pcv = $urandom & ~32'd1;
                imv = 32'($urandom_range(0, 255)) - 32'd128;
                if ($urandom_range(0, 15) != 0) imv[0] = 1'b0;
                opv = $urandom;
                if (fu_op'(4'(k)) == ADD) begin
                    set_port(p, ADD, pcv, opv, imv, 1'($urandom_range(0, 1)), 1'b1, Jump, pcv + imv);
                end else if (fu_op'(4'(k)) == JALR) begin
                    t = (opv + imv) & ~32'd1;
                    r = $urandom_range(0, 7);
                    set_port(p, JALR, pcv, opv, imv, 1'($urandom_range(0, 1)), 1'b1,
                             (r == 0) ? NoCF : ((r == 1) ? Return : JumpR),
                             (r == 2) ? t + 32'd4 : t);
                end else begin
                    cr = 1'($urandom_range(0, 1));
                    set_port(p, fu_op'(4'(k)), pcv, opv, imv, 1'($urandom_range(0, 1)), cr,
                             ($urandom_range(0, 7) == 0) ? (cr ? NoCF : Branch) : (cr ? Branch : NoCF),
                             pcv + imv);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        res_ready = 1'b0;
        clear_ports();
        repeat (2) tick();
        rst = 1'b0;

        // Single taken BEQ predicted NoCF.
        set_port(0, EQ, 32'h1000, 32'h0, 32'h20, 1'b0, 1'b1, NoCF, 32'h0);
        tick();
        clear_ports();
        chk("t1_valid", 160'(res_valid), 160'(1));
        chk("t1_target", 160'(rb.target_address), 160'(32'h1020));
        chk("t1_mispredict", 160'(rb.is_mispredict), 160'(1));
        chk("t1_cf", 160'(rb.cf_type), 160'(Branch));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Two ports: compressed JAL then not-taken branch.
        set_port(0, ADD, 32'h2000, 32'h0, 32'h100, 1'b1, 1'b1, Jump, 32'h2100);
        set_port(1, EQ, 32'h2002, 32'h0, 32'h40, 1'b0, 1'b0, NoCF, 32'h0);
        #1;
        chk("t2_link0", 160'(result[0]), 160'(32'h2002));
        tick();
        clear_ports();
        chk("t2_head0_target", 160'(rb.target_address), 160'(32'h2100));
        res_ready = 1'b1;
        tick();
        chk("t2_head1_pc", 160'(rb.pc), 160'(32'h2002));
        chk("t2_head1_target", 160'(rb.target_address), 160'(32'h2006));
        tick();
        res_ready = 1'b0;

        // Fill to DEPTH, extra push ignored, one pop does not reopen.
        set_port(0, LTU, 32'h5000, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h5008);
        set_port(1, LTU, 32'h5004, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h500c);
        repeat (2) tick();
        chk("t3_full_occ", 160'(occ), 160'(4));
        chk("t3_full_ready", 160'(ready), 160'(0));
        tick();
        chk("t3_ignored_occ", 160'(occ), 160'(4));
        clear_ports();
        res_ready = 1'b1;
        tick();
        chk("t3_pop_occ", 160'(occ), 160'(3));
        chk("t3_pop_ready", 160'(ready), 160'(0));
        repeat (3) tick();
        res_ready = 1'b0;

        // Head mispredict squashes three younger entries.
        set_port(0, EQ, 32'h6000, 32'h0, 32'h10, 1'b0, 1'b1, NoCF, 32'h0);
        set_port(1, LTU, 32'h6004, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h600c);
        tick();
        set_port(0, LTU, 32'h6010, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h6018);
        set_port(1, LTU, 32'h6014, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h601c);
        tick();
        res_ready = 1'b1;
        tick();
        chk("t4_squash_occ", 160'(occ), 160'(0));
        res_ready = 1'b0;
        // Squash also drops pushes made in the retiring cycle.
        set_port(0, EQ, 32'h6100, 32'h0, 32'h10, 1'b0, 1'b1, NoCF, 32'h0);
        set_port(1, LTU, 32'h6104, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h610c);
        tick();
        res_ready = 1'b1;
        set_port(0, LTU, 32'h6200, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h6208);
        set_port(1, LTU, 32'h6204, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h620c);
        tick();
        chk("t4_same_cycle_occ", 160'(occ), 160'(0));
        clear_ports();
        res_ready = 1'b0;

        // JALR clears bit 0; taken BNE to odd target faults.
        set_port(0, JALR, 32'h2ff0, 32'h3001, 32'h0, 1'b0, 1'b1, JumpR, 32'h3000);
        set_port(1, NE, 32'h4000, 32'h0, 32'h3, 1'b0, 1'b1, Branch, 32'h4003);
        tick();
        clear_ports();
        chk("t5_jalr_target", 160'(rb.target_address), 160'(32'h3000));
        chk("t5_jalr_exc", 160'(rex.valid), 160'(0));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t5_bne_exc", 160'(rex.valid), 160'(1));
        chk("t5_bne_tval", 160'(rex.tval), 160'(64'h4000));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Flush with pop handshake and push in the same cycle.
        set_port(0, LTU, 32'h7000, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h7008);
        tick();
        res_ready = 1'b1;
        flush     = 1'b1;
        set_port(1, LTU, 32'h7010, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h7018);
        tick();
        flush     = 1'b0;
        res_ready = 1'b0;
        clear_ports();
        chk("t6_flush_occ", 160'(occ), 160'(0));
        chk("t6_flush_valid", 160'(res_valid), 160'(0));

        // Reset mid-operation.
        set_port(0, LTU, 32'h8000, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h8008);
        set_port(1, LTU, 32'h8004, 32'h0, 32'h8, 1'b0, 1'b1, Branch, 32'h800c);
        tick();
        clear_ports();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t7_reset_occ", 160'(occ), 160'(0));
        chk("t7_reset_ready", 160'(ready), 160'(1));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_ports();
            res_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            tick();
        end
        clear_ports();
        flush     = 1'b0;
        res_ready = 1'b1;
        repeat (10) tick();
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
